// File: rtl/quad_frame_loader.sv
// Serial-to-parallel frame loader: receives KW-bit target k (MSB first) then N array bits,
// and presents the assembled array, k and ones count over a valid/ack handshake.
module quad_frame_loader #(
    parameter int N  = 100,
    parameter int KW = 8,
    parameter int OW = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_data,
    input  logic          in_last,
    output logic [N-1:0]  out_array,
    output logic [KW-1:0] out_k,
    output logic [OW-1:0] out_ones,
    output logic          out_valid,
    input  logic          out_ack,
    output logic          frame_err
);

    localparam int MAXW = (KW > N) ? KW : N;
    localparam int CW   = (MAXW > 1) ? $clog2(MAXW) : 1;

    typedef enum logic [1:0] {LOAD_K, LOAD_ARR, PRESENT} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [N-1:0]  shadow_array;
    logic [KW-1:0] shadow_k;
    logic [OW-1:0] shadow_ones;

    logic          xfer;
    logic          k_last;
    logic          arr_last;
    logic [N-1:0]  arr_final;
    logic [OW-1:0] ones_final;

    assign xfer       = in_valid && in_ready;
    assign k_last     = (cnt == CW'(KW - 1));
    assign arr_last   = (cnt == CW'(N - 1));
    assign ones_final = shadow_ones + OW'(in_data);

    // Final bit N-1 is merged combinationally so completion publishes in the same edge.
    always_comb begin
        arr_final        = shadow_array;
        arr_final[N-1]   = in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= LOAD_K;
            cnt          <= '0;
            shadow_array <= '0;
            shadow_k     <= '0;
            shadow_ones  <= '0;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            frame_err    <= 1'b0;
            out_array    <= '0;
            out_k        <= '0;
            out_ones     <= '0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                LOAD_K: begin
                    if (xfer) begin
                        if (in_last) begin
                            frame_err <= 1'b1;
                            cnt       <= '0;
                            shadow_k  <= '0;
                        end else begin
                            shadow_k <= {shadow_k[KW-2:0], in_data};
                            if (k_last) begin
                                cnt   <= '0;
                                state <= LOAD_ARR;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                    end
                end
                LOAD_ARR: begin
                    if (xfer) begin
                        if (in_last != arr_last) begin
                            frame_err    <= 1'b1;
                            cnt          <= '0;
                            shadow_array <= '0;
                            shadow_k     <= '0;
                            shadow_ones  <= '0;
                            state        <= LOAD_K;
                        end else if (arr_last) begin
                            out_array <= arr_final;
                            out_k     <= shadow_k;
                            out_ones  <= ones_final;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                            state     <= PRESENT;
                        end else begin
                            shadow_array[cnt] <= in_data;
                            shadow_ones       <= ones_final;
                            cnt               <= cnt + CW'(1);
                        end
                    end
                end
                PRESENT: begin
                    if (out_ack) begin
                        out_valid    <= 1'b0;
                        in_ready     <= 1'b1;
                        cnt          <= '0;
                        shadow_array <= '0;
                        shadow_k     <= '0;
                        shadow_ones  <= '0;
                        state        <= LOAD_K;
                    end
                end
                default: state <= LOAD_K;
            endcase
        end
    end

endmodule

// File: tb/tb_quad_frame_loader.sv
// Directed self-checking bench for quad_frame_loader with hand-computed frame results.
module tb_quad_frame_loader;

    localparam int N  = 100;
    localparam int KW = 8;
    localparam int OW = 7;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          in_data;
    logic          in_last;
    logic [N-1:0]  out_array;
    logic [KW-1:0] out_k;
    logic [OW-1:0] out_ones;
    logic          out_valid;
    logic          out_ack;
    logic          frame_err;

    int tests;
    int fails;

    quad_frame_loader #(.N(N), .KW(KW), .OW(OW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_array (out_array),
        .out_k     (out_k),
        .out_ones  (out_ones),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transfer; waits (bounded) for in_ready, optionally stalls in_valid first.
    task automatic send_bit(input logic d, input logic last, input bit stall);
        int waited;
        if (stall) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
        end
        waited = 0;
        while (!in_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!in_ready) check("ready_timeout", 128'(in_ready), 128'(1));
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Sends the first n_bits of frame {k, arr}; in_last asserted on global bit index last_at.
    task automatic send_frame(input logic [KW-1:0] k, input logic [N-1:0] arr,
                              input int n_bits, input int last_at, input bit stall);
        logic d;
        for (int i = 0; i < n_bits; i++) begin
            d = (i < KW) ? k[KW-1-i] : arr[i-KW];
            send_bit(d, (i == last_at), stall);
        end
    endtask

    task automatic ack();
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
    endtask

    logic [N-1:0] arr_f1, arr_ones, arr_alt, arr_ends;

    initial begin
        tests    = 0;
        fails    = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 1'b0;
        in_last  = 1'b0;
        out_ack  = 1'b0;
        arr_f1   = 100'hF;
        arr_ones = '1;
        arr_alt  = {50{2'b10}};
        arr_ends = '0;
        arr_ends[0]   = 1'b1;
        arr_ends[N-1] = 1'b1;

        repeat (3) tick();
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_frame_err", 128'(frame_err), 128'(0));
        check("rst_out_array", 128'(out_array), 128'(0));
        rst_n = 1'b1;
        tick();

        // Frame 1: k=4, bits 0..3 set
        send_frame(8'h04, arr_f1, KW + N, KW + N - 1, 1'b0);
        check("f1_valid", 128'(out_valid), 128'(1));
        check("f1_k", 128'(out_k), 128'(4));
        check("f1_array", 128'(out_array), 128'(arr_f1));
        check("f1_ones", 128'(out_ones), 128'(4));
        check("f1_ready", 128'(in_ready), 128'(0));

        // Hold without ack while upstream offers ones
        in_valid = 1'b1;
        in_data  = 1'b1;
        repeat (10) tick();
        check("hold_valid", 128'(out_valid), 128'(1));
        check("hold_array", 128'(out_array), 128'(arr_f1));
        check("hold_ready", 128'(in_ready), 128'(0));
        in_valid = 1'b0;
        in_data  = 1'b0;
        ack();
        check("ack_valid", 128'(out_valid), 128'(0));
        check("ack_ready", 128'(in_ready), 128'(1));
        check("ack_keep_k", 128'(out_k), 128'(4));

        // Frame 2: k=0, all ones
        send_frame(8'h00, arr_ones, KW + N, KW + N - 1, 1'b0);
        check("f2_k", 128'(out_k), 128'(0));
        check("f2_array", 128'(out_array), 128'(arr_ones));
        check("f2_ones", 128'(out_ones), 128'(100));
        ack();
        ack();
        check("ack_idle_ignored", 128'(out_valid), 128'(0));

        // Frame 3 unstalled, then stalled: same result
        send_frame(8'hFF, arr_alt, KW + N, KW + N - 1, 1'b0);
        check("f3_k", 128'(out_k), 128'(255));
        check("f3_array", 128'(out_array), 128'(arr_alt));
        check("f3_ones", 128'(out_ones), 128'(50));
        ack();
        send_frame(8'hFF, arr_alt, KW + N, KW + N - 1, 1'b1);
        check("f3s_k", 128'(out_k), 128'(255));
        check("f3s_array", 128'(out_array), 128'(arr_alt));
        check("f3s_ones", 128'(out_ones), 128'(50));
        ack();

        // Early in_last on array bit 50
        send_frame(8'h12, arr_ones, KW + 51, KW + 50, 1'b0);
        check("early_err", 128'(frame_err), 128'(1));
        check("early_valid", 128'(out_valid), 128'(0));
        tick();
        check("early_err_pulse", 128'(frame_err), 128'(0));
        check("early_keep_array", 128'(out_array), 128'(arr_alt));
        check("early_keep_k", 128'(out_k), 128'(255));

        // Recovery frame exercises bit 0 and bit N-1
        send_frame(8'hA5, arr_ends, KW + N, KW + N - 1, 1'b0);
        check("rec_valid", 128'(out_valid), 128'(1));
        check("rec_k", 128'(out_k), 128'(8'hA5));
        check("rec_array", 128'(out_array), 128'(arr_ends));
        check("rec_ones", 128'(out_ones), 128'(2));
        ack();

        // Missing in_last on bit 99
        send_frame(8'h33, arr_f1, KW + N, -1, 1'b0);
        check("nolast_err", 128'(frame_err), 128'(1));
        check("nolast_valid", 128'(out_valid), 128'(0));
        tick();
        check("nolast_pulse", 128'(frame_err), 128'(0));

        // in_last on a k bit
        send_frame(8'h33, arr_f1, 3, 2, 1'b0);
        check("klast_err", 128'(frame_err), 128'(1));
        tick();
        check("klast_pulse", 128'(frame_err), 128'(0));
        send_frame(8'h07, arr_f1, KW + N, KW + N - 1, 1'b0);
        check("post_klast_k", 128'(out_k), 128'(7));
        check("post_klast_ones", 128'(out_ones), 128'(4));
        ack();

        // Async reset mid-array (bit 60)
        send_frame(8'h55, arr_ones, KW + 60, -1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_array", 128'(out_array), 128'(0));
        check("rst_mid_k", 128'(out_k), 128'(0));
        check("rst_mid_ones", 128'(out_ones), 128'(0));
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_mid_ready", 128'(in_ready), 128'(1));

        // Async reset in PRESENT
        send_frame(8'h04, arr_f1, KW + N, KW + N - 1, 1'b0);
        check("pre_rst_valid", 128'(out_valid), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        check("rst_pres_valid", 128'(out_valid), 128'(0));
        check("rst_pres_array", 128'(out_array), 128'(0));
        check("rst_pres_ready", 128'(in_ready), 128'(1));
        tick();
        rst_n = 1'b1;
        tick();
        send_frame(8'h09, arr_ends, KW + N, KW + N - 1, 1'b0);
        check("final_k", 128'(out_k), 128'(9));
        check("final_array", 128'(out_array), 128'(arr_ends));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
